// File: rtl/lut_reverse_search_if.sv
// Request/response bundle for the sequential LUT reverse search.
// The master side issues the search; the slave side is the search engine.
interface lut_reverse_search_if #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8
);
    localparam int W     = KEY_LEN + DATA_LEN;
    localparam int IDX_W = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;

    logic                   req_valid;
    logic                   req_ready;
    logic [DATA_LEN-1:0]    req_data;
    logic [KEY_LEN-1:0]     default_key;
    logic [NR_KEY*W-1:0]    lut;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [KEY_LEN-1:0]     rsp_key;
    logic                   rsp_hit;
    logic [IDX_W-1:0]       rsp_idx;

    modport master (
        output req_valid, req_data, default_key, lut, rsp_ready,
        input  req_ready, rsp_valid, rsp_key, rsp_hit, rsp_idx
    );

    modport slave (
        input  req_valid, req_data, default_key, lut, rsp_ready,
        output req_ready, rsp_valid, rsp_key, rsp_hit, rsp_idx
    );
endinterface

// File: rtl/lut_reverse_search.sv
// Sequential reverse lookup over a packed {key,data} LUT: returns the key of the
// first entry whose data equals the request, scanning one entry per cycle.
module lut_reverse_search #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    lut_reverse_search_if.slave bus
);
    localparam int W     = KEY_LEN + DATA_LEN;
    localparam int IDX_W = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Snapshot of the request taken at acceptance so the search ignores later port changes.
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] target_q;
    logic [KEY_LEN-1:0]  default_q;

    logic [KEY_LEN-1:0]  rsp_key_q, rsp_key_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;

    logic accept;
    logic entry_match;

    assign accept      = bus.req_valid && (state_q == IDLE);
    assign entry_match = (data_q[idx_q] == target_q);

    // NOTE: the snapshot is pure datapath qualified by accept, so it carries no
    // reset; nothing reads it before the first accepted request loads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            target_q  <= bus.req_data;
            default_q <= bus.default_key;
            for (int i = 0; i < NR_KEY; i++) begin
                {key_q[i], data_q[i]} <= bus.lut[(NR_KEY-i)*W-1 -: W];
            end
        end
    end

    // NOTE: state and result registers use non-blocking <= so every flop samples
    // the pre-edge values; the combinational process below uses blocking =.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rsp_key_q <= '0;
            rsp_hit_q <= 1'b0;
            rsp_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rsp_key_q <= rsp_key_d;
            rsp_hit_q <= rsp_hit_d;
            rsp_idx_q <= rsp_idx_d;
        end
    end

    // NOTE: every output of this process is given a hold-value default first, so
    // no branch leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rsp_key_d = rsp_key_q;
        rsp_hit_d = rsp_hit_q;
        rsp_idx_d = rsp_idx_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (entry_match) begin
                    rsp_key_d = key_q[idx_q];
                    rsp_hit_d = 1'b1;
                    rsp_idx_d = idx_q;
                    state_d   = RESP;
                end else if (idx_q == LAST_IDX) begin
                    rsp_key_d = default_q;
                    rsp_hit_d = 1'b0;
                    rsp_idx_d = '0;
                    state_d   = RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags decode straight from the state register, so neither has a
    // combinational path from the request side.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_key   = rsp_key_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;

endmodule

// File: tb/tb_lut_reverse_search.sv
// Self-checking bench for lut_reverse_search: directed test-plan steps followed by
// randomized searches compared against a first-match reference model.
module tb_lut_reverse_search;
    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 2;
    localparam int DATA_LEN = 8;
    localparam int W        = KEY_LEN + DATA_LEN;

    typedef struct {
        logic [KEY_LEN-1:0] key;
        logic               hit;
        logic [1:0]         idx;
        int                 lat;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
    logic [DATA_LEN-1:0] tbl_data [NR_KEY];

    lut_reverse_search_if #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) bus ();

    lut_reverse_search #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First matching entry wins; a miss walks the whole table.
    function automatic result_t model(input logic [DATA_LEN-1:0] target,
                                      input logic [KEY_LEN-1:0] def);
        result_t r;
        r.key = def;
        r.hit = 1'b0;
        r.idx = '0;
        r.lat = NR_KEY;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (tbl_data[i] == target) begin
                r.key = tbl_key[i];
                r.hit = 1'b1;
                r.idx = 2'(i);
                r.lat = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [NR_KEY*W-1:0] pack_lut();
        logic [NR_KEY*W-1:0] v;
        v = '0;
        for (int i = 0; i < NR_KEY; i++) v[(NR_KEY-i)*W-1 -: W] = {tbl_key[i], tbl_data[i]};
        return v;
    endfunction

    task automatic load_default_lut();
        for (int i = 0; i < NR_KEY; i++) begin
            tbl_key[i]  = KEY_LEN'(i);
            tbl_data[i] = 8'h11 * 8'(i + 1);
        end
    endtask

    // One full search: issue, wait for the response, optionally backpressure, consume.
    task automatic run_search(input string tag, input logic [DATA_LEN-1:0] target,
                              input logic [KEY_LEN-1:0] def, input int hold,
                              input bit early, input bit scramble);
        result_t exp;
        int      cyc;
        int      lat;
        exp = model(target, def);
        bus.req_data    = target;
        bus.default_key = def;
        bus.lut         = pack_lut();
        bus.rsp_ready   = early;
        bus.req_valid   = 1'b1;
        cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, " accept_timeout"}, 32'(cyc < 64), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (scramble) bus.lut = {NR_KEY{{2'b11, target}}};
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp.lat));
        check({tag, " key"}, 32'(bus.rsp_key), 32'(exp.key));
        check({tag, " hit"}, 32'(bus.rsp_hit), 32'(exp.hit));
        check({tag, " idx"}, 32'(bus.rsp_idx), 32'(exp.idx));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check({tag, " hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                check({tag, " hold_ready"}, 32'(bus.req_ready), 32'd0);
                check({tag, " hold_key"}, 32'(bus.rsp_key), 32'(exp.key));
                check({tag, " hold_idx"}, 32'(bus.rsp_idx), 32'(exp.idx));
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, " done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " done_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " kept_key"}, 32'(bus.rsp_key), 32'(exp.key));
        check({tag, " kept_hit"}, 32'(bus.rsp_hit), 32'(exp.hit));
        if (scramble) bus.lut = pack_lut();
    endtask

    initial begin
        int cyc;
        int lat;
        bus.req_valid   = 1'b0;
        bus.req_data    = '0;
        bus.default_key = '0;
        bus.rsp_ready   = 1'b0;
        load_default_lut();
        bus.lut = pack_lut();

        // Reset state
        #12;
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_key", 32'(bus.rsp_key), 32'd0);
        check("rst rsp_hit", 32'(bus.rsp_hit), 32'd0);
        check("rst rsp_idx", 32'(bus.rsp_idx), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed test-plan cases
        run_search("hit0", 8'h11, 2'b11, 0, 1'b1, 1'b0);
        run_search("hit_last", 8'h44, 2'b00, 0, 1'b1, 1'b0);
        run_search("miss", 8'h55, 2'b10, 2, 1'b0, 1'b0);
        tbl_data[3] = 8'h22;
        run_search("dup_bp", 8'h22, 2'b00, 5, 1'b0, 1'b1);
        load_default_lut();

        // Reset mid-scan aborts the search
        bus.lut = pack_lut();
        bus.req_data = 8'h44;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort in_scan", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort rsp_key", 32'(bus.rsp_key), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Back-to-back with req_valid held high
        bus.rsp_ready = 1'b1;
        bus.req_data  = 8'h33;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        check("b2b first_lat", 32'(lat), 32'd3);
        check("b2b first_key", 32'(bus.rsp_key), 32'h2);
        bus.req_data = 8'h11;
        @(posedge clk); #1;
        check("b2b idle_gap", 32'(bus.req_ready), 32'd1);
        check("b2b idle_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("b2b second_accept", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1; cyc++;
        end
        check("b2b second_lat", 32'(cyc), 32'd1);
        check("b2b second_key", 32'(bus.rsp_key), 32'h0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;

        // Randomized searches over small data alphabets so hits and duplicates occur
        for (int n = 0; n < 24; n++) begin
            int hold;
            bit early;
            for (int i = 0; i < NR_KEY; i++) begin
                tbl_key[i]  = KEY_LEN'($urandom_range(0, 3));
                tbl_data[i] = 8'($urandom_range(0, 5));
            end
            hold  = int'($urandom_range(0, 3));
            early = (hold == 0) && ($urandom_range(0, 1) == 1);
            run_search("rand", 8'($urandom_range(0, 7)), KEY_LEN'($urandom_range(0, 3)),
                       hold, early, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
